// File: rtl/sw_parity_pkg.sv
// Shared types and default constants for the switch-parity controller.
package sw_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_SW_DEF       = 8;
    localparam int DEB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a debounce counter, or by a
// single extra register when SW_PARITY_DEBOUNCE_EN is not defined.
module sw_debounce
    import sw_parity_pkg::*;
`ifdef SW_PARITY_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_stable
);

    logic [1:0] sync_reg;
    logic       stable_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], sw};
        end
    end

`ifdef SW_PARITY_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_reg;

    // Any return to the stable level restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else if (sync_reg[1] == stable_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            stable_reg <= sync_reg[1];
            cnt_reg    <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_reg <= 1'b0;
        end else begin
            stable_reg <= sync_reg[1];
        end
    end
`endif

    assign sw_stable = stable_reg;

endmodule

// File: rtl/sw_parity_ctrl.sv
// Switch-parity sequencer: conditions the switches, detects a settled change and
// runs a serial popcount scan. Debounce is built only with SW_PARITY_DEBOUNCE_EN.
module sw_parity_ctrl
    import sw_parity_pkg::*;
#(
    parameter int N_SW       = N_SW_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    localparam int PC_W      = $clog2(N_SW + 1)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] sw_stable,
    output logic [PC_W-1:0] pop_count,
    output logic            led_odd,
    output logic            busy,
    output logic            done
);

    localparam int IDX_W = (N_SW > 1) ? $clog2(N_SW) : 1;
`ifdef SW_PARITY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_bit
            sw_debounce
`ifdef SW_PARITY_DEBOUNCE_EN
            #(
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W)
            )
`endif
            u_deb (
                .clk       (clk),
                .rst_n     (rst_n),
                .sw        (sw[gi]),
                .sw_stable (sw_stable[gi])
            );
        end
    endgenerate

    state_t          state_reg;
    logic [N_SW-1:0] snapshot_reg;
    logic [N_SW-1:0] last_eval_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [PC_W-1:0] acc_reg;
    logic [PC_W-1:0] pop_count_reg;
    logic            led_odd_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            req;

    assign req = (sw_stable != last_eval_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            snapshot_reg  <= '0;
            last_eval_reg <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            pop_count_reg <= '0;
            led_odd_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        snapshot_reg  <= sw_stable;
                        last_eval_reg <= sw_stable;
                        idx_reg       <= '0;
                        acc_reg       <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= SCAN;
                    end
                end
                // The snapshot stays frozen here; later changes wait for the next IDLE.
                SCAN: begin
                    acc_reg <= acc_reg + PC_W'(snapshot_reg[idx_reg]);
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(N_SW - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    pop_count_reg <= acc_reg;
                    led_odd_reg   <= acc_reg[0];
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pop_count = pop_count_reg;
    assign led_odd   = led_odd_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_sw_parity_ctrl.sv
// Scoreboard bench for sw_parity_ctrl: expected scan results are queued as switches
// are driven and popped on every done pulse.
module tb_sw_parity_ctrl;

    localparam int N_SW = 8;
    localparam int PC_W = 4;
    localparam int DEB  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_SW-1:0] sw = '0;
    logic [N_SW-1:0] sw_stable;
    logic [PC_W-1:0] pop_count;
    logic            led_odd;
    logic            busy;
    logic            done;

    sw_parity_ctrl #(
        .N_SW       (N_SW),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .sw_stable (sw_stable),
        .pop_count (pop_count),
        .led_odd   (led_odd),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cycle    = 0;
    int busy_run = 0;
    logic [PC_W:0] exp_q[$];
    logic [PC_W:0] mon_e;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    function automatic void push(input int pc, input bit odd);
        exp_q.push_back({PC_W'(pc), odd});
    endfunction

    // Scoreboard side: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, 9);
                busy_run = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexp_done", done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("scan done: cycle=%0d pop_count=%0d led_odd=%0b exp=%0d/%0b",
                             cycle, pop_count, led_odd, mon_e[PC_W:1], mon_e[0]);
                    check("pop_count", pop_count, mon_e[PC_W:1]);
                    check("led_odd", led_odd, mon_e[0]);
                end
            end
        end
    end

    task automatic set_sw(input logic [N_SW-1:0] v);
        @(posedge clk);
        #1 sw = v;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_SW-1:0] seen;
        logic [N_SW-1:0] exp_seen;
        int c0;
        int n;

        // Reset with all switches up.
        sw = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stable0", sw_stable, 8'h00);
        check("rst_pop", pop_count, 0);
        check("rst_odd", led_odd, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        push(8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain("reset");
        check("rst_stable_ff", sw_stable, 8'hFF);

        // Single bit with latency measurement.
        push(0, 0);
        set_sw(8'h00);
        wait_drain("clear1");
        push(1, 1);
        set_sw(8'h01);
        n = 0;
        while (sw_stable == 8'h00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        c0 = cycle;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", cycle - c0, 10);
        check("stable_01", sw_stable, 8'h01);
        wait_drain("single");

        // Two-cycle glitch on bit 3.
        push(0, 0);
        set_sw(8'h00);
        wait_drain("clear2");
`ifdef SW_PARITY_DEBOUNCE_EN
        exp_seen = 8'h00;
`else
        exp_seen = 8'h08;
        push(1, 1);
        push(0, 0);
`endif
        @(posedge clk);
        #1 sw = 8'h08;
        @(posedge clk);
        @(posedge clk);
        #1 sw = 8'h00;
        seen = '0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | sw_stable;
        end
        check("glitch_seen", seen, exp_seen);
        wait_drain("glitch");

        // Change while a scan is in flight.
        push(3, 1);
        set_sw(8'h07);
        wait_busy("mid");
        push(4, 0);
        set_sw(8'h0F);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mid_first_done", done, 1);
        @(negedge clk);
        check("mid_restart", busy, 1);
        wait_drain("mid");

        // Reset during a scan on 8'hAA.
        set_sw(8'hAA);
        wait_busy("abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_stable", sw_stable, 8'h00);
        check("abort_pop", pop_count, 0);
        check("abort_odd", led_odd, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(posedge clk);
        push(4, 0);
        #1 rst_n = 1'b1;
        wait_drain("abort");

        // Seven bits in one step.
        push(0, 0);
        set_sw(8'h00);
        wait_drain("clear3");
        push(7, 1);
        set_sw(8'h7F);
        wait_drain("simul");
        check("simul_stable", sw_stable, 8'h7F);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_parity_ctrl.md
Name: sw_parity_ctrl

Overview:
- Sequencing controller for the Basys3 switch-parity datapath.
- Synchronises and optionally debounces the 8 slide switches, then detects a settled change in the switch word.
- Runs a serial one-bit-per-cycle popcount scan and drives the odd-parity LED plus a popcount result.
- Sits between the board switch pins and the LED/seven-segment logic. All logic is on a single clock domain, `clk`.

Parameters:
- N_SW, 8: number of switch inputs scanned.
- DEB_CYCLES, 1000000: consecutive stable cycles required before a debounced bit changes (10 ms at 100 MHz).
- CNT_W, $clog2(DEB_CYCLES+1): debounce counter width (derived).
- PC_W, $clog2(N_SW+1): popcount width (derived, 4 for N_SW=8).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; asynchronous, active-low.
- sw  in  N_SW  raw switch pins, asynchronous to clk.
- sw_stable  out  N_SW  synchronised/debounced switch word.
- pop_count  out  PC_W  number of '1' bits in the last evaluated word.
- led_odd  out  1  1 when the last evaluated word has odd parity.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when pop_count and led_odd have just updated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sync flops, sw_stable, debounce counters, snapshot, last_eval, idx, acc, pop_count, led_odd, busy and done are all cleared to 0.
  - FSM goes to IDLE.
  - Asserting reset mid-scan aborts the scan immediately; no done pulse is produced.
- Input path: two-flop synchroniser per bit, giving sync[N_SW-1:0].
- Debounce (per bit):
  - If sync[i] == sw_stable[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] reaches DEB_CYCLES-1, sw_stable[i] takes sync[i] on that edge and cnt[i] clears.
  - A glitch shorter than DEB_CYCLES cycles never reaches sw_stable.
- Change request: req = (sw_stable != last_eval).
- FSM states:
  - IDLE:
    - If req: snapshot <= sw_stable; last_eval <= sw_stable; idx <= 0; acc <= 0; busy <= 1; go to SCAN.
    - Otherwise stay in IDLE.
  - SCAN:
    - acc <= acc + snapshot[idx]; idx <= idx + 1.
    - When idx == N_SW-1, go to DONE.
    - Takes exactly N_SW cycles.
  - DONE:
    - pop_count <= acc; led_odd <= acc[0]; done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: sw_stable changes at edge k, so IDLE sees req at edge k+1 and done is high during cycle k+N_SW+2. For N_SW=8, done is high 10 cycles after the stable change.
- Changes during SCAN: the snapshot is frozen, so the in-flight result reflects the captured word. A new difference against last_eval is picked up in IDLE on the cycle after DONE; no change is lost.
- Several bits settling on the same edge produce a single scan.
- A word that returns to last_eval before IDLE samples it triggers no scan.
- Arithmetic:
  - acc is PC_W bits wide and cannot overflow, since its maximum value is N_SW.
  - idx is $clog2(N_SW) bits wide and never wraps within a scan.
- pop_count and led_odd hold their value between scans.

Optional Feature:
- Macro: SW_PARITY_DEBOUNCE_EN.
- Defined: debounce counters present; behaviour exactly as above.
- Undefined:
  - No counters are built.
  - sw_stable = sync, registered once more, giving 3-flop latency from pin.
  - DEB_CYCLES is ignored.
  - All FSM behaviour is unchanged.

Decomposition:
- Shared package sw_parity_pkg holds:
  - the state enum: IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - the default constants N_SW_DEF=8 and DEB_CYCLES_DEF=1000000.
- One sub-module, sw_debounce:
  - a single-bit synchroniser plus debounce counter;
  - instantiated N_SW times via generate;
  - contains the SW_PARITY_DEBOUNCE_EN conditional.
- The FSM and scan datapath stay in sw_parity_ctrl.

Test Plan (bench uses DEB_CYCLES=4):
- Reset: hold rst_n=0 with sw=8'hFF, then release. sw_stable=8'h00, led_odd=0, pop_count=0, done=0 and busy=0 during reset. sw_stable reaches 8'hFF after sync+4 cycles, followed by one done pulse with pop_count=8 and led_odd=0.
- Single bit: sw 8'h00 -> 8'h01, held. done fires N_SW+2=10 cycles after sw_stable changes; pop_count=1, led_odd=1; busy is high for exactly 9 cycles.
- Glitch reject: pulse sw[3] high for 2 cycles. sw_stable stays 8'h00 and there is no done pulse. Without SW_PARITY_DEBOUNCE_EN, the same glitch appears on sw_stable and produces two scans (result 1 then 0).
- Mid-scan change: start a scan on 8'h07, then change sw to 8'h0F once sw_stable has updated during SCAN. First done gives pop_count=3, led_odd=1. A second scan starts the cycle after DONE, and its done gives pop_count=4, led_odd=0.
- Reset mid-scan: drop rst_n during SCAN with word 8'hAA. There is no done pulse and outputs clear. After release, with sw=8'hAA, one scan gives pop_count=4, led_odd=0.
- Simultaneous bits: sw 8'h00 -> 8'h7F in one step. Exactly one done pulse, with pop_count=7 and led_odd=1.
